// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: one state per clock, memory stalls via mem_ready.
// Optional feature: define MC_JUMP_EN to build the JMP state and decode OP_J.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
    JMP    = 4'd9
  } state_t;

  state_t stateQ;
  logic   opLegal;

  always_comb begin
    opLegal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: opLegal = 1'b1;
`ifdef MC_JUMP_EN
      OP_J:                           opLegal = 1'b1;
`endif
      default:                        opLegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= FETCH;
    end else begin
      case (stateQ)
        FETCH:  if (mem_ready) stateQ <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: stateQ <= MEMADR;
            OP_RTYPE:     stateQ <= REX;
            OP_BEQ:       stateQ <= BEQ;
`ifdef MC_JUMP_EN
            OP_J:         stateQ <= JMP;
`endif
            default:      stateQ <= FETCH;
          endcase
        end
        MEMADR: begin
          if (opcode == OP_LW)      stateQ <= MEMRD;
          else if (opcode == OP_SW) stateQ <= MEMWR;
          else                      stateQ <= FETCH;
        end
        MEMRD:  if (mem_ready) stateQ <= MEMWB;
        MEMWR:  if (mem_ready) stateQ <= FETCH;
        REX:    stateQ <= RWB;
        default: stateQ <= FETCH;
      endcase
    end
  end

  // Moore decode; only the FETCH PC/IR loads and the MEMWR retire look at mem_ready.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    retire      = 1'b0;
    illegal_op  = 1'b0;
    case (stateQ)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = ~opLegal;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
      end
      REX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
      end
`ifdef MC_JUMP_EN
      JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state = stateQ;

endmodule
